ecdh_ctrl: RTL

- Sequencing controller that sits directly upstream of the scalar multiplier over GF(2^4), curve y^2+xy = x^3+ax^2+1 with reduction polynomial f.
- Runs a two-phase ECDH exchange on one shared multiplier instance:
  - public key Pub = k*G;
  - after a peer point B arrives, shared secret S = k*B.
- Drives the multiplier operands, waits a fixed settle time, then captures the multiplier outputs.
- The point at infinity O is encoded as (0,0).

---
 rtl/ecdh_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ecdh_ctrl.sv
// ecdh_ctrl: sequences Pub = k*G then S = k*B on one shared GF(2^4) scalar multiplier,
// sampling its result a fixed settle time after each operand presentation.
module ecdh_ctrl #(
   parameter int SETTLE_CYCLES = 16
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [3:0] i_priv_k,
   input  logic [3:0] i_gx,
   input  logic [3:0] i_gy,
   input  logic [4:0] i_a_in,
   input  logic [4:0] i_f_in,
   input  logic       i_peer_valid,
   output logic       o_peer_ready,
   input  logic [3:0] i_peer_x,
   input  logic [3:0] i_peer_y,
   output logic [3:0] o_sm_k,
   output logic [3:0] o_sm_px,
   output logic [3:0] o_sm_py,
   output logic [4:0] o_sm_a,
   output logic [4:0] o_sm_f,
   input  logic [3:0] i_sm_qx,
   input  logic [3:0] i_sm_qy,
   output logic       o_busy,
   output logic       o_pub_valid,
   output logic [3:0] o_pub_x,
   output logic [3:0] o_pub_y,
   output logic [3:0] o_sec_x,
   output logic [3:0] o_sec_y,
   output logic       o_done,
   output logic       o_err
);
   typedef enum logic [1:0] {IDLE, WAIT_PUB, WAIT_PEER, WAIT_SEC} state_t;
   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);
   state_t     r_state, w_state;
   logic [7:0] r_cnt, w_cnt;
   logic [3:0] r_sm_k, w_sm_k, r_sm_px, w_sm_px, r_sm_py, w_sm_py;
   logic [4:0] r_sm_a, w_sm_a, r_sm_f, w_sm_f;
   logic       r_pub_valid, w_pub_valid, r_done, w_done, r_err, w_err;
   logic [3:0] r_pub_x, w_pub_x, r_pub_y, w_pub_y, r_sec_x, w_sec_x, r_sec_y, w_sec_y;
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_sm_k      = r_sm_k;
      w_sm_px     = r_sm_px;
      w_sm_py     = r_sm_py;
      w_sm_a      = r_sm_a;
      w_sm_f      = r_sm_f;
      w_pub_valid = r_pub_valid;
      w_pub_x     = r_pub_x;
      w_pub_y     = r_pub_y;
      w_sec_x     = r_sec_x;
      w_sec_y     = r_sec_y;
      w_done      = 1'b0;
      w_err       = r_err;
      case (r_state)
         IDLE: if (i_start) begin
            if (i_priv_k != 4'd0) begin
               w_sm_k      = i_priv_k;
               w_sm_px     = i_gx;
               w_sm_py     = i_gy;
               w_sm_a      = i_a_in;
               w_sm_f      = i_f_in;
               w_pub_valid = 1'b0;
               w_err       = 1'b0;
               w_cnt       = CNT_LOAD;
               w_state     = WAIT_PUB;
            end else begin
               w_done = 1'b1;
               w_err  = 1'b1;
            end
         end
         WAIT_PUB: if (r_cnt == 8'd0) begin
            w_pub_x     = i_sm_qx;
            w_pub_y     = i_sm_qy;
            w_pub_valid = 1'b1;
            w_state     = WAIT_PEER;
         end else w_cnt = r_cnt - 8'd1;
         WAIT_PEER: if (i_peer_valid) begin
            // an infinity peer point aborts the exchange but keeps the public key
            if ({i_peer_x, i_peer_y} != 8'd0) begin
               w_sm_px = i_peer_x;
               w_sm_py = i_peer_y;
               w_cnt   = CNT_LOAD;
               w_state = WAIT_SEC;
            end else begin
               w_done  = 1'b1;
               w_err   = 1'b1;
               w_state = IDLE;
            end
         end
         WAIT_SEC: if (r_cnt == 8'd0) begin
            w_sec_x = i_sm_qx;
            w_sec_y = i_sm_qy;
            w_done  = 1'b1;
            w_err   = {i_sm_qx, i_sm_qy} == 8'd0;
            w_state = IDLE;
         end else w_cnt = r_cnt - 8'd1;
      endcase
   end
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_sm_k      <= '0;
         r_sm_px     <= '0;
         r_sm_py     <= '0;
         r_sm_a      <= '0;
         r_sm_f      <= '0;
         r_pub_valid <= 1'b0;
         r_pub_x     <= '0;
         r_pub_y     <= '0;
         r_sec_x     <= '0;
         r_sec_y     <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_sm_k      <= w_sm_k;
         r_sm_px     <= w_sm_px;
         r_sm_py     <= w_sm_py;
         r_sm_a      <= w_sm_a;
         r_sm_f      <= w_sm_f;
         r_pub_valid <= w_pub_valid;
         r_pub_x     <= w_pub_x;
         r_pub_y     <= w_pub_y;
         r_sec_x     <= w_sec_x;
         r_sec_y     <= w_sec_y;
         r_done      <= w_done;
         r_err       <= w_err;
      end
   end
   assign o_peer_ready = r_state == WAIT_PEER;
   assign o_busy       = r_state != IDLE;
   assign o_sm_k       = r_sm_k;
   assign o_sm_px      = r_sm_px;
   assign o_sm_py      = r_sm_py;
   assign o_sm_a       = r_sm_a;
   assign o_sm_f       = r_sm_f;
   assign o_pub_valid  = r_pub_valid;
   assign o_pub_x      = r_pub_x;
   assign o_pub_y      = r_pub_y;
   assign o_sec_x      = r_sec_x;
   assign o_sec_y      = r_sec_y;
   assign o_done       = r_done;
   assign o_err        = r_err;
endmodule
